// File: rtl/lpc_io_dispatch.sv
// LPC I/O backend dispatcher: decodes four address windows and runs one
// strobe/acknowledge handshake at a time with the selected target device.
module lpc_io_dispatch #(
    parameter logic [15:0] WIN0_BASE = 16'h0080,
    parameter logic [15:0] WIN0_MASK = 16'hFFFF,
    parameter logic [15:0] WIN1_BASE = 16'h03F8,
    parameter logic [15:0] WIN1_MASK = 16'hFFF8,
    parameter logic [15:0] WIN2_BASE = 16'h0000,
    parameter logic [15:0] WIN2_MASK = 16'hFFFF,
    parameter logic [15:0] WIN3_BASE = 16'h0000,
    parameter logic [15:0] WIN3_MASK = 16'hFFFF,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        lclk,
    input  logic        lreset_n,
    input  logic [3:0]  win_en,
    input  logic        lpc_en,
    input  logic [15:0] lpc_addr,
    input  logic        lpc_io_rden,
    input  logic        lpc_io_wren,
    input  logic [7:0]  lpc_wdata,
    output logic        addr_hit,
    output logic [7:0]  lpc_rdata,
    output logic        lpc_ready,
    output logic [3:0]  dev_cs,
    output logic        dev_rd,
    output logic        dev_wr,
    output logic [2:0]  dev_offset,
    output logic [7:0]  dev_wdata,
    input  logic [31:0] dev_rdata,
    input  logic [3:0]  dev_ack,
    output logic        timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [3:0]  hit;
    logic [3:0]  sel_oh_d;
    logic [1:0]  sel_idx_d;
    logic [1:0]  idx_q;
    logic        is_rd_q;
    logic [7:0]  cnt_q;
    logic        ack_seen_q;
    logic [7:0]  cap_q;
    logic        ack_sel;
    logic [7:0]  byte_sel;

    logic [7:0]  lpc_rdata_q;
    logic        lpc_ready_q;
    logic [3:0]  dev_cs_q;
    logic        dev_rd_q;
    logic        dev_wr_q;
    logic [2:0]  dev_offset_q;
    logic [7:0]  dev_wdata_q;
    logic        timeout_err_q;

    always_comb begin
        hit[0] = win_en[0] & ((lpc_addr & WIN0_MASK) == (WIN0_BASE & WIN0_MASK));
        hit[1] = win_en[1] & ((lpc_addr & WIN1_MASK) == (WIN1_BASE & WIN1_MASK));
        hit[2] = win_en[2] & ((lpc_addr & WIN2_MASK) == (WIN2_BASE & WIN2_MASK));
        hit[3] = win_en[3] & ((lpc_addr & WIN3_MASK) == (WIN3_BASE & WIN3_MASK));
    end

    assign addr_hit = lpc_en & (|hit);

    // Overlapping windows resolve to the lowest index.
    always_comb begin
        sel_oh_d  = 4'b0000;
        sel_idx_d = 2'd0;
        if (hit[0]) begin
            sel_oh_d = 4'b0001; sel_idx_d = 2'd0;
        end else if (hit[1]) begin
            sel_oh_d = 4'b0010; sel_idx_d = 2'd1;
        end else if (hit[2]) begin
            sel_oh_d = 4'b0100; sel_idx_d = 2'd2;
        end else if (hit[3]) begin
            sel_oh_d = 4'b1000; sel_idx_d = 2'd3;
        end
    end

    always_comb begin
        byte_sel = 8'h00;
        case (idx_q)
            2'd0: byte_sel = dev_rdata[7:0];
            2'd1: byte_sel = dev_rdata[15:8];
            2'd2: byte_sel = dev_rdata[23:16];
            default: byte_sel = dev_rdata[31:24];
        endcase
    end

    assign ack_sel = |(dev_ack & dev_cs_q);

    always_ff @(posedge lclk) begin
        if (!lreset_n) begin
            state_q       <= S_IDLE;
            idx_q         <= 2'd0;
            is_rd_q       <= 1'b0;
            cnt_q         <= 8'd0;
            ack_seen_q    <= 1'b0;
            cap_q         <= 8'h00;
            lpc_rdata_q   <= 8'h00;
            lpc_ready_q   <= 1'b0;
            dev_cs_q      <= 4'h0;
            dev_rd_q      <= 1'b0;
            dev_wr_q      <= 1'b0;
            dev_offset_q  <= 3'd0;
            dev_wdata_q   <= 8'h00;
            timeout_err_q <= 1'b0;
        end else begin
            dev_rd_q    <= 1'b0;
            dev_wr_q    <= 1'b0;
            lpc_ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (lpc_en && lpc_io_rden && lpc_io_wren) begin
                        timeout_err_q <= 1'b1;
                    end else if (addr_hit && (lpc_io_rden ^ lpc_io_wren)) begin
                        dev_cs_q     <= sel_oh_d;
                        idx_q        <= sel_idx_d;
                        dev_offset_q <= lpc_addr[2:0];
                        dev_wdata_q  <= lpc_wdata;
                        is_rd_q      <= lpc_io_rden;
                        dev_rd_q     <= lpc_io_rden;
                        dev_wr_q     <= lpc_io_wren;
                        state_q      <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (!lpc_en) begin
                        dev_cs_q <= 4'h0;
                        state_q  <= S_IDLE;
                    end else begin
                        // A same-cycle ack is remembered and honoured in WAIT.
                        cnt_q      <= 8'd0;
                        ack_seen_q <= ack_sel;
                        cap_q      <= byte_sel;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!lpc_en) begin
                        dev_cs_q <= 4'h0;
                        state_q  <= S_IDLE;
                    end else if (ack_seen_q || ack_sel) begin
                        if (is_rd_q) lpc_rdata_q <= ack_seen_q ? cap_q : byte_sel;
                        lpc_ready_q <= 1'b1;
                        dev_cs_q    <= 4'h0;
                        state_q     <= S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        if (is_rd_q) lpc_rdata_q <= 8'hFF;
                        timeout_err_q <= 1'b1;
                        lpc_ready_q   <= 1'b1;
                        dev_cs_q      <= 4'h0;
                        state_q       <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign lpc_rdata   = lpc_rdata_q;
    assign lpc_ready   = lpc_ready_q;
    assign dev_cs      = dev_cs_q;
    assign dev_rd      = dev_rd_q;
    assign dev_wr      = dev_wr_q;
    assign dev_offset  = dev_offset_q;
    assign dev_wdata   = dev_wdata_q;
    assign timeout_err = timeout_err_q;

endmodule
